// File: rtl/overlap_add.sv
// overlap_add: streaming overlap-add reconstruction for 50%-overlapped frames.
//
// Each frame is 2N input samples. The first half (ADD phase) is summed with the
// second half of the previous frame, saturated to W bits and streamed out. The
// second half (STORE phase) is written to an N-entry overlap buffer and produces
// no output.
//
// Parameters
//   halfWindowSize : N, samples per half window (power of two, >= 2)
//   wordLength     : W, signed sample width
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : upstream sample present
//   in_data    : upstream sample (signed, W bits)
//   in_ready   : block accepts in_data this cycle
//   out_valid  : out_data holds a reconstructed sample
//   out_data   : overlap-added sample (signed, W bits)
//   out_sat    : out_data was clamped
//   out_last   : out_data is sample N-1 of its frame
//   out_ready  : downstream accepts out_data this cycle
module overlap_add #(
    parameter int unsigned halfWindowSize = 512,
    parameter int unsigned wordLength     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [wordLength-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [wordLength-1:0] out_data,
    output logic                  out_sat,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int unsigned W     = wordLength;
    localparam int unsigned AddrW = $clog2(halfWindowSize);
    localparam int unsigned IdxW  = AddrW + 1;

    localparam logic [W-1:0] MaxVal = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0] MinVal = {1'b1, {(W - 1){1'b0}}};

    logic [IdxW-1:0]  idx_q, idx_d;
    logic             primed_q, primed_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             out_sat_q, out_sat_d;
    logic             out_last_q, out_last_d;

    // Overlap buffer: deliberately not reset, primed_q masks stale contents.
    logic [W-1:0]     buf_q [halfWindowSize];

    logic             phase_store;
    logic [AddrW-1:0] addr;
    logic             in_xfer;
    logic             out_xfer;
    logic [W-1:0]     addend;
    logic [W:0]       sum;
    logic             overflow;

    // N is a power of two, so the index MSB is the phase and the low bits address the buffer.
    assign phase_store = idx_q[IdxW-1];
    assign addr        = idx_q[AddrW-1:0];

    assign in_ready = !rst && (phase_store || !out_valid_q || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    assign addend   = primed_q ? buf_q[addr] : '0;
    assign sum      = {in_data[W-1], in_data} + {addend[W-1], addend};
    // Overflow of a W-bit sum shows up as the two top bits of the W+1-bit sum disagreeing.
    assign overflow = sum[W] ^ sum[W-1];

    always_comb begin
        idx_d       = idx_q;
        primed_d    = primed_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_last_d  = out_last_q;

        if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        if (in_xfer) begin
            idx_d = idx_q + 1'b1;
            if (phase_store) begin
                if (&idx_q) begin
                    primed_d = 1'b1;
                end
            end else begin
                out_valid_d = 1'b1;
                out_sat_d   = overflow;
                out_last_d  = &addr;
                if (overflow) begin
                    out_data_d = sum[W] ? MinVal : MaxVal;
                end else begin
                    out_data_d = sum[W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_last_q  <= out_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_xfer && phase_store) begin
            buf_q[addr] <= in_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_overlap_add.sv
// tb_overlap_add: directed and randomised checks of overlap_add with N=4, W=16.
module tb_overlap_add;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_last;
    logic        out_ready = 1'b1;

    int total  = 0;
    int passed = 0;

    typedef struct {
        int d;
        int s;
        int l;
    } exp_t;

    exp_t q[$];
    int   mbuf[4];
    int   midx;
    int   mprimed;

    overlap_add #(
        .halfWindowSize(4),
        .wordLength    (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sat  (out_sat),
        .out_last (out_last),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Present one sample and return at the falling edge after it was accepted.
    task automatic push(input int d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = 16'(d);
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("push_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int d, input int s, input int l);
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk({tag, "_data"}, int'($signed(out_data)), d);
        chk({tag, "_sat"}, int'(out_sat), s);
        chk({tag, "_last"}, int'(out_last), l);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_unexpected_out"}, 1, 0);
        end else begin
            e = q.pop_front();
            chk({tag, "_data"}, int'($signed(out_data)), e.d);
            chk({tag, "_sat"}, int'(out_sat), e.s);
            chk({tag, "_last"}, int'(out_last), e.l);
        end
    endtask

    initial begin
        int d;
        int s;
        int n_in;
        int cyc;
        exp_t e;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        chk("rst_out_last", int'(out_last), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);

        // Frame 1: unprimed, outputs are the raw ADD inputs
        push(1);  expect_out("f1_0", 1, 0, 0);
        push(2);  expect_out("f1_1", 2, 0, 0);
        push(3);  expect_out("f1_2", 3, 0, 0);
        push(4);  expect_out("f1_3", 4, 0, 1);
        push(10); chk("store_no_out", int'(out_valid), 0);
        push(20);
        push(30);
        push(40);

        // Frame 2: adds previous STORE half
        push(5); expect_out("f2_0", 15, 0, 0);
        push(5); expect_out("f2_1", 25, 0, 0);
        push(5); expect_out("f2_2", 35, 0, 0);
        push(5); expect_out("f2_3", 45, 0, 1);
        push(32000);
        push(-32000);
        push(0);
        push(0);

        // Frame 3: saturation at both rails
        push(1000);  expect_out("sat_hi", 32767, 1, 0);
        push(-1000); expect_out("sat_lo", -32768, 1, 0);
        push(0);     expect_out("sat_none", 0, 0, 0);
        push(0);     expect_out("sat_last", 0, 0, 1);
        push(100);
        push(200);
        push(300);
        push(400);

        // Frame 4: back-pressure for 3 cycles
        push(1); expect_out("bp_first", 101, 0, 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'd2;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_data", int'($signed(out_data)), 101);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        expect_out("bp_release", 202, 0, 0);
        push(3); expect_out("bp_2", 303, 0, 0);
        push(4); expect_out("bp_3", 404, 0, 1);
        push(50);
        push(50);
        push(50);
        push(50);

        // Frame 5 partial: 4 ADD + 2 STORE, then reset mid-frame
        push(1); expect_out("f5_0", 51, 0, 0);
        push(2);
        push(3);
        push(4);
        push(6);
        push(6);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", int'(in_ready), 0);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out_data", int'(out_data), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // New unprimed frame ignores stale buffer contents
        push(7); expect_out("rst_f_0", 7, 0, 0);
        push(7); expect_out("rst_f_1", 7, 0, 0);
        push(7); expect_out("rst_f_2", 7, 0, 0);
        push(7); expect_out("rst_f_3", 7, 0, 1);
        push(8);
        push(8);
        push(8);
        push(8);
        push(1); expect_out("reprimed", 9, 0, 0);

        // Random flow against a reference model, starting from reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        midx    = 0;
        mprimed = 0;
        n_in    = 0;
        cyc     = 0;
        while (n_in < 400 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) pop_check("rnd");
            if (in_valid && in_ready) begin
                d = int'($signed(in_data));
                if (midx < 4) begin
                    s = d + (mprimed != 0 ? mbuf[midx] : 0);
                    e.s = 0;
                    if (s > 32767) begin
                        s = 32767;
                        e.s = 1;
                    end else if (s < -32768) begin
                        s = -32768;
                        e.s = 1;
                    end
                    e.d = s;
                    e.l = (midx == 3) ? 1 : 0;
                    q.push_back(e);
                end else begin
                    mbuf[midx - 4] = d;
                    if (midx == 7) mprimed = 1;
                end
                midx = (midx + 1) % 8;
                n_in++;
            end
        end
        chk("rnd_inputs_done", n_in, 400);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (out_valid) pop_check("drain");
        end
        chk("rnd_queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
